// File: rtl/auth_request_arbiter_pkg.sv
// Shared definitions for the authentication request arbiter: descriptor field
// ranges, init_resp codes, FSM state encoding and requester source ids.
package auth_request_arbiter_pkg;

   localparam int unsigned DESC_W        = 8;

   // Descriptor layout: {slot, init_resp, usb, type}
   localparam int unsigned SLOT_MSB      = 7;
   localparam int unsigned SLOT_LSB      = 6;
   localparam int unsigned INIT_RESP_MSB = 5;
   localparam int unsigned INIT_RESP_LSB = 4;
   localparam int unsigned USB_MSB       = 3;
   localparam int unsigned USB_LSB       = 2;
   localparam int unsigned TYPE_MSB      = 1;
   localparam int unsigned TYPE_LSB      = 0;

   localparam logic [1:0] INIT_RESP_RESPONDER = 2'b01;
   localparam logic [1:0] INIT_RESP_INITIATOR = 2'b10;

   localparam logic SRC_PD    = 1'b0;
   localparam logic SRC_DEBUG = 1'b1;

   // One-hot arbiter states
   typedef enum logic [2:0] {
      StIdle  = 3'b001,
      StGrant = 3'b010,
      StBusy  = 3'b100
   } arb_state_e;

   // A descriptor is usable only if it names a responder or an initiator
   function automatic logic desc_is_bad(input logic [DESC_W-1:0] desc);
      logic [1:0] ir;
      ir = desc[INIT_RESP_MSB:INIT_RESP_LSB];
      return !((ir == INIT_RESP_RESPONDER) || (ir == INIT_RESP_INITIATOR));
   endfunction

endpackage

// File: rtl/auth_request_arbiter_fifo.sv
// auth_req_fifo: synchronous show-ahead FIFO holding 8-bit request descriptors.
// Push while full and pop while empty are ignored; push+pop together keep count.
module auth_req_fifo import auth_request_arbiter_pkg::*; #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DESC_W-1:0]             din,
   output logic [DESC_W-1:0]             dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DESC_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              push_ok, pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers and occupancy; pointers wrap naturally since depth is a power of 2
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage needs no reset; pointers define which entries are live
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= din;
   end

   assign dout  = mem[rd_ptr_q];
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/auth_request_arbiter.sv
// auth_request_arbiter: queues PD and DEBUG authentication descriptors and
// grants them one at a time to the driver, holding off the next grant until
// auth_done or a BUSY timeout. Malformed head descriptors are dropped.
// Build option: AUTH_ARB_DEBUG_PRIORITY_EN gives DEBUG strict priority over PD;
// otherwise the two queues are served round-robin.
module auth_request_arbiter import auth_request_arbiter_pkg::*; #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TIMEOUT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pd_req_valid,
   input  logic [DESC_W-1:0]             pd_req_data,
   output logic                          pd_req_ready,
   input  logic                          debug_req_valid,
   input  logic [DESC_W-1:0]             debug_req_data,
   output logic                          debug_req_ready,
   output logic                          grant_valid,
   output logic [DESC_W-1:0]             grant_data,
   output logic                          grant_src,
   input  logic                          grant_ready,
   input  logic                          auth_done,
   output logic                          err_timeout,
   output logic                          err_bad_desc,
   output logic [$clog2(FIFO_DEPTH):0]   pd_count,
   output logic [$clog2(FIFO_DEPTH):0]   debug_count
);

   arb_state_e            state_q, state_d;
   logic                  last_src_q, last_src_d;
   logic [DESC_W-1:0]     grant_data_q, grant_data_d;
   logic                  grant_src_q, grant_src_d;
   logic [TIMEOUT_W-1:0]  timer_q, timer_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  err_bad_q, err_bad_d;

   logic                  pd_pop, debug_pop;
   logic                  pd_full, pd_empty, debug_full, debug_empty;
   logic [DESC_W-1:0]     pd_head, debug_head;
   logic                  sel_valid, sel_src;
   logic [DESC_W-1:0]     sel_data;

   auth_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_pd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pd_req_valid),
      .pop   (pd_pop),
      .din   (pd_req_data),
      .dout  (pd_head),
      .full  (pd_full),
      .empty (pd_empty),
      .count (pd_count)
   );

   auth_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_debug_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (debug_req_valid),
      .pop   (debug_pop),
      .din   (debug_req_data),
      .dout  (debug_head),
      .full  (debug_full),
      .empty (debug_empty),
      .count (debug_count)
   );

   // Pick which queue head the IDLE state looks at
   always_comb begin
      sel_valid = !pd_empty || !debug_empty;
`ifdef AUTH_ARB_DEBUG_PRIORITY_EN
      sel_src = debug_empty ? SRC_PD : SRC_DEBUG;
`else
      if (!pd_empty && !debug_empty) sel_src = ~last_src_q;
      else if (!pd_empty)            sel_src = SRC_PD;
      else                           sel_src = SRC_DEBUG;
`endif
      sel_data = (sel_src == SRC_DEBUG) ? debug_head : pd_head;
   end

   // Next-state, queue pops and error pulses
   always_comb begin
      state_d       = state_q;
      last_src_d    = last_src_q;
      grant_data_d  = grant_data_q;
      grant_src_d   = grant_src_q;
      timer_d       = timer_q;
      err_timeout_d = 1'b0;
      err_bad_d     = 1'b0;
      pd_pop        = 1'b0;
      debug_pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sel_valid) begin
               if (desc_is_bad(sel_data)) begin
                  err_bad_d = 1'b1;
                  if (sel_src == SRC_DEBUG) debug_pop = 1'b1;
                  else                      pd_pop    = 1'b1;
               end else begin
                  grant_data_d = sel_data;
                  grant_src_d  = sel_src;
                  state_d      = StGrant;
               end
            end
         end
         StGrant: begin
            // Head stays queued until the driver takes it
            if (grant_ready) begin
               if (grant_src_q == SRC_DEBUG) debug_pop = 1'b1;
               else                          pd_pop    = 1'b1;
               last_src_d = grant_src_q;
               timer_d    = '0;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            if (auth_done) begin
               state_d = StIdle;
            end else if (timer_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
               err_timeout_d = 1'b1;
               state_d       = StIdle;
            end else begin
               timer_d = timer_q + TIMEOUT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; last_src resets to DEBUG so PD wins the first tie
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         last_src_q    <= SRC_DEBUG;
         grant_data_q  <= '0;
         grant_src_q   <= SRC_PD;
         timer_q       <= '0;
         err_timeout_q <= 1'b0;
         err_bad_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_src_q    <= last_src_d;
         grant_data_q  <= grant_data_d;
         grant_src_q   <= grant_src_d;
         timer_q       <= timer_d;
         err_timeout_q <= err_timeout_d;
         err_bad_q     <= err_bad_d;
      end
   end

   assign pd_req_ready    = !pd_full;
   assign debug_req_ready = !debug_full;
   assign grant_valid     = (state_q == StGrant);
   assign grant_data      = grant_data_q;
   assign grant_src       = grant_src_q;
   assign err_timeout     = err_timeout_q;
   assign err_bad_desc    = err_bad_q;

endmodule

// File: tb/tb_auth_request_arbiter.sv
// Self-checking bench for auth_request_arbiter: a queue-based reference model
// is checked every cycle, plus directed scenarios with literal expectations.
module tb_auth_request_arbiter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TC    = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pd_req_valid = 1'b0;
   logic [7:0] pd_req_data = 8'h00;
   logic       pd_req_ready;
   logic       debug_req_valid = 1'b0;
   logic [7:0] debug_req_data = 8'h00;
   logic       debug_req_ready;
   logic       grant_valid;
   logic [7:0] grant_data;
   logic       grant_src;
   logic       grant_ready = 1'b0;
   logic       auth_done = 1'b0;
   logic       err_timeout;
   logic       err_bad_desc;
   logic [2:0] pd_count;
   logic [2:0] debug_count;

   auth_request_arbiter #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TC),
      .TIMEOUT_W      (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pd_req_valid    (pd_req_valid),
      .pd_req_data     (pd_req_data),
      .pd_req_ready    (pd_req_ready),
      .debug_req_valid (debug_req_valid),
      .debug_req_data  (debug_req_data),
      .debug_req_ready (debug_req_ready),
      .grant_valid     (grant_valid),
      .grant_data      (grant_data),
      .grant_src       (grant_src),
      .grant_ready     (grant_ready),
      .auth_done       (auth_done),
      .err_timeout     (err_timeout),
      .err_bad_desc    (err_bad_desc),
      .pd_count        (pd_count),
      .debug_count     (debug_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_bad = 0;
   int n_to = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: two queues, a phase (0 idle, 1 offering, 2 driver busy)
   logic [7:0] q_pd[$];
   logic [7:0] q_dbg[$];
   int         m_phase = 0;
   bit         m_last = 1'b1;
   logic [7:0] m_data = 8'h00;
   bit         m_src = 1'b0;
   int         m_busy = 0;
   bit         m_bad = 1'b0;
   bit         m_to = 1'b0;
   bit         model_ok = 1'b0;
   bit         pd_in, dbg_in, pick_dbg;
   logic [7:0] head;
   logic [1:0] ir;

   always @(posedge clk) begin
      if (!reset) begin
         q_pd.delete();
         q_dbg.delete();
         m_phase = 0; m_last = 1'b1; m_data = 8'h00; m_src = 1'b0;
         m_busy = 0; m_bad = 1'b0; m_to = 1'b0; model_ok = 1'b1;
      end else begin
         pd_in  = pd_req_valid && (q_pd.size() < DEPTH);
         dbg_in = debug_req_valid && (q_dbg.size() < DEPTH);
         m_bad = 1'b0;
         m_to  = 1'b0;
         if (m_phase == 0) begin
            if (q_pd.size() > 0 || q_dbg.size() > 0) begin
`ifdef AUTH_ARB_DEBUG_PRIORITY_EN
               pick_dbg = (q_dbg.size() > 0);
`else
               pick_dbg = (q_pd.size() == 0) || (q_dbg.size() > 0 && m_last == 1'b0);
`endif
               head = pick_dbg ? q_dbg[0] : q_pd[0];
               ir = head[5:4];
               if (ir == 2'b00 || ir == 2'b11) begin
                  m_bad = 1'b1;
                  if (pick_dbg) void'(q_dbg.pop_front());
                  else          void'(q_pd.pop_front());
               end else begin
                  m_data = head;
                  m_src = pick_dbg;
                  m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            if (grant_ready) begin
               if (m_src) void'(q_dbg.pop_front());
               else       void'(q_pd.pop_front());
               m_last = m_src;
               m_busy = 0;
               m_phase = 2;
            end
         end else begin
            // m_busy = number of BUSY cycles completed
            m_busy++;
            if (auth_done) m_phase = 0;
            else if (m_busy == TC) begin
               m_to = 1'b1;
               m_phase = 0;
            end
         end
         if (pd_in)  q_pd.push_back(pd_req_data);
         if (dbg_in) q_dbg.push_back(debug_req_data);
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (err_bad_desc === 1'b1) n_bad++;
      if (err_timeout === 1'b1)  n_to++;
      if (model_ok) begin
         chk("pd_req_ready", pd_req_ready, q_pd.size() < DEPTH);
         chk("debug_req_ready", debug_req_ready, q_dbg.size() < DEPTH);
         chk("pd_count", pd_count, q_pd.size());
         chk("debug_count", debug_count, q_dbg.size());
         chk("grant_valid", grant_valid, m_phase == 1);
         if (m_phase == 1) begin
            chk("grant_data", grant_data, m_data);
            chk("grant_src", grant_src, m_src);
         end
         chk("err_bad_desc", err_bad_desc, m_bad);
         chk("err_timeout", err_timeout, m_to);
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic push(input bit to_pd, input bit to_dbg, input logic [7:0] pd_d,
                       input logic [7:0] dbg_d);
      pd_req_valid = to_pd;  pd_req_data = pd_d;
      debug_req_valid = to_dbg; debug_req_data = dbg_d;
      @(posedge clk); #2;
      pd_req_valid = 1'b0; debug_req_valid = 1'b0;
   endtask

   // Wait (bounded) for a grant, accept it, optionally pulse auth_done
   task automatic serve(output logic [7:0] d, output logic s, input bit done);
      int n = 0;
      while (grant_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (grant_valid !== 1'b1) begin
         chk("grant_wait", 0, 1);
         d = 8'hxx; s = 1'bx;
         return;
      end
      d = grant_data; s = grant_src;
      grant_ready = 1'b1;
      @(posedge clk); #2;
      grant_ready = 1'b0;
      if (done) begin
         auth_done = 1'b1;
         @(posedge clk); #2;
         auth_done = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       s;
      logic [7:0] exp3 [8];
      int         t0, b0, o0;

      // 1: reset with valids held high
      pd_req_valid = 1'b1; debug_req_valid = 1'b1;
      pd_req_data = 8'h51; debug_req_data = 8'h21;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      pd_req_valid = 1'b0; debug_req_valid = 1'b0;
      reset = 1'b1;
      chk("rst_pd_count", pd_count, 0);
      chk("rst_debug_count", debug_count, 0);
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_pd_ready", pd_req_ready, 1);
      chk("rst_debug_ready", debug_req_ready, 1);

      // 2: single PD request, latency N+2
      push(1'b1, 1'b0, 8'h51, 8'h00);
      chk("lat_idle_n1", grant_valid, 0);
      @(posedge clk); #2;
      chk("lat_grant_n2", grant_valid, 1);
      chk("t2_data", grant_data, 8'h51);
      chk("t2_src", grant_src, 0);
      serve(d, s, 1'b1);
      chk("t2_count", pd_count, 0);

      // 3: both queues full, grant order
      do_reset();
      for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 8'h11 + 8'(i), 8'h21 + 8'(i));
`ifdef AUTH_ARB_DEBUG_PRIORITY_EN
      exp3 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h11, 8'h12, 8'h13, 8'h14};
`else
      exp3 = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24};
`endif
      for (int i = 0; i < 8; i++) begin
         serve(d, s, 1'b1);
         chk($sformatf("order_%0d", i), d, exp3[i]);
      end

      // 4: overflow of the PD queue
      do_reset();
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 8'h11 + 8'(i), 8'h00);
      chk("ovf_ready_after4", pd_req_ready, 0);
      push(1'b1, 1'b0, 8'h15, 8'h00);
      chk("ovf_count", pd_count, 4);
      for (int i = 0; i < 4; i++) begin
         serve(d, s, 1'b1);
         chk($sformatf("ovf_order_%0d", i), d, 8'h11 + 8'(i));
      end
      repeat (4) @(posedge clk);
      #2;
      chk("ovf_5th_lost", grant_valid, 0);
      chk("ovf_drained", pd_count, 0);

      // 5: malformed descriptor dropped
      do_reset();
      b0 = n_bad;
      push(1'b1, 1'b0, 8'h00, 8'h00);
      push(1'b1, 1'b0, 8'h61, 8'h00);
      serve(d, s, 1'b1);
      chk("bad_next_data", d, 8'h61);
      chk("bad_next_src", s, 0);
      chk("bad_pulses", n_bad - b0, 1);

      // 6: timeout and reset in BUSY
      do_reset();
      push(1'b1, 1'b0, 8'h12, 8'h00);
      push(1'b1, 1'b0, 8'h13, 8'h00);
      serve(d, s, 1'b0);
      t0 = cyc;
      chk("to_first", d, 8'h12);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         if (err_timeout === 1'b1) break;
      end
      chk("to_delay", cyc - t0, 8);
      serve(d, s, 1'b1);
      chk("to_next", d, 8'h13);
      push(1'b1, 1'b0, 8'h14, 8'h00);
      serve(d, s, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      b0 = n_bad; o0 = n_to;
      reset = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      chk("rst_busy_grant", grant_valid, 0);
      repeat (12) @(posedge clk);
      #2;
      chk("rst_busy_no_to", n_to - o0, 0);
      chk("rst_busy_no_bad", n_bad - b0, 0);
      chk("rst_busy_idle", grant_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
